vec_pipe_ctrl: RTL and testbench
================================

Name: vec_pipe_ctrl

Overview:
Hazard and sequencing controller for the vector CPU's ID/EX pipeline stage.
- Load-use hazards: detects a load in EX whose destination is read by the instruction in ID, and inserts one bubble.
- Vector load/store: when a vector (LDS) memory instruction reaches EX, it freezes the front end and walks the R lanes through the single scalar memory port, one lane per acknowledged beat.
- Watchdog: a lane that never receives mem_ack is aborted and reported as an error.

Parameters:
N, 8, element width in bits (interface consistency only; no N-wide datapath inside)
R, 6, vector lanes per register
TMO, 15, max cycles to wait for mem_ack on one lane before abort (TMO >= 1)

Ports:
clk  in  1  clock; state updates on posedge, so outputs are stable before the pipeline registers' negedge capture
reset  in  1  asynchronous, active-high
RA1D  in  4  source register 1 of the instruction in ID
RA2D  in  4  source register 2 of the instruction in ID
WA3E  in  4  destination register of the instruction in EX
MemtoRegE  in  1  EX instruction is a load
MemWriteE  in  1  EX instruction is a store
LDSFlagE  in  1  EX memory op is vector (all R lanes)
mem_ack  in  1  memory port completed the current lane beat
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register (vector walk in progress)
FlushE  out  1  clear ID/EX on the next capture (bubble)
mem_req  out  1  request a lane beat on the memory port
lane_idx  out  $clog2(R)  lane currently addressed
vec_busy  out  1  vector walk active
vec_err  out  1  sticky; set on watchdog abort

Behaviour:
- Reset values: state=IDLE, lane_idx=0, watchdog count=0, vec_err=0. All other outputs are 0.
- FSM states: IDLE, VWALK, VLAST.
- Vector op start condition (vstart): LDSFlagE & (MemtoRegE | MemWriteE).
- IDLE:
  - If vstart: go to VWALK, lane_idx=0, count=0.
  - If R==1, go directly to VLAST instead.
- VWALK: mem_req=1, vec_busy=1, StallF=StallD=StallE=1.
  - On mem_ack: lane_idx++ and count=0.
  - If the new lane_idx==R-1, go to VLAST.
- VLAST: mem_req=1, vec_busy=1, StallF=StallD=StallE=1.
  - On mem_ack: go to IDLE and set lane_idx=0.
  - The stalls drop combinationally in the following cycle, so EX advances exactly once.
- Watchdog (VWALK/VLAST only):
  - count increments each cycle that mem_ack=0.
  - When count reaches TMO: set vec_err=1, go to IDLE, lane_idx=0, and pulse FlushE for 1 cycle (the faulting op is killed).
  - vec_err is cleared only by reset.
- Load-use hazard, evaluated only in IDLE with vstart=0:
  - Fires when MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
  - Outputs: StallF=StallD=FlushE=1 for exactly one cycle. Combinational; no state change.
  - All 16 register addresses are compared; there is no hard-wired zero register.
- Vector load in EX with a dependent instruction in ID: vstart has priority. After the walk, the loaded register is written before the dependent instruction reads it, so no extra bubble is inserted.
- mem_ack in IDLE is ignored.
- mem_ack in the same cycle the watchdog reaches TMO: the ack wins, the lane advances, and no error is raised.
- lane_idx never exceeds R-1. Increments saturate at R-1.
- Reset asserted mid-walk: immediate return to IDLE and all outputs to 0. No partial-completion signalling.

Decomposition:
- Shared package vec_cpu_pkg holds:
  - the state enum typedef (IDLE, VWALK, VLAST);
  - localparam LANE_W = $clog2(R);
  - localparam TMO_W = $clog2(TMO+1).
- One sub-module: vec_lane_watchdog. It is a counter with clear, enable, and a terminal flag. The FSM and the hazard comparator stay in vec_pipe_ctrl.

Test Plan:
1. Reset mid-walk: R=6, vstart, 2 acks, then assert reset → lane_idx=0, mem_req=0, StallE=0 immediately, state IDLE.
2. Load-use: MemtoRegE=1, LDSFlagE=0, WA3E=3, RA2D=3 → StallF=StallD=FlushE=1 for exactly 1 cycle. Repeat with RA1D=RA2D=4 → all 0.
3. Full vector load: vstart, mem_ack every cycle → lane_idx 0,1,2,3,4,5 on consecutive cycles, mem_req/StallE high for 6 cycles, then low. vec_err=0.
4. Slow memory: acks arriving 3 cycles apart → each lane holds 3 cycles, total walk is 18 cycles, no error.
5. Timeout: TMO=15, ack lane 0 only, then silence → after 15 idle cycles vec_err=1, FlushE pulses 1 cycle, state IDLE, stalls released. vec_err stays set until reset.
6. Ack on the terminal cycle: mem_ack arrives exactly when count==TMO → the lane advances, vec_err remains 0.

Source files
------------

// File: rtl/vec_cpu_pkg.sv
// Shared types and default sizing for the vector CPU ID/EX control slice.
// Pure declarations; no latency or flow control.
package vec_cpu_pkg;

    localparam int VEC_N   = 8;
    localparam int VEC_R   = 6;
    localparam int VEC_TMO = 15;

    localparam int LANE_W = $clog2(VEC_R);
    localparam int TMO_W  = $clog2(VEC_TMO + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VWALK = 2'd1,
        VLAST = 2'd2
    } vec_state_t;

    // Width of an index/counter covering n values, never below one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_lane_watchdog.sv
// Per-lane wait counter: counts enabled cycles, saturates at TMO and flags it.
// Latency: term is registered-count compare, valid the cycle count reaches TMO.
// Backpressure: none; clr dominates en.
module vec_lane_watchdog #(
    parameter int TMO = 15,
    parameter int CW  = $clog2(TMO + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [CW-1:0] count;

    assign term = (count == CW'(TMO));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !term) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/vec_pipe_ctrl.sv
// ID/EX hazard and vector load/store sequencing controller.
// Latency: load-use bubble is combinational; vector walk advances one lane per mem_ack.
// Backpressure: freezes IF/ID/EX while walking; watchdog aborts a lane with no ack.
module vec_pipe_ctrl
    import vec_cpu_pkg::*;
#(
    parameter int N   = VEC_N,
    parameter int R   = VEC_R,
    parameter int TMO = VEC_TMO
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 RA1D,
    input  logic [3:0]                 RA2D,
    input  logic [3:0]                 WA3E,
    input  logic                       MemtoRegE,
    input  logic                       MemWriteE,
    input  logic                       LDSFlagE,
    input  logic                       mem_ack,
    output logic                       StallF,
    output logic                       StallD,
    output logic                       StallE,
    output logic                       FlushE,
    output logic                       mem_req,
    output logic [min1_clog2(R)-1:0]   lane_idx,
    output logic                       vec_busy,
    output logic                       vec_err
);

    localparam int LW = min1_clog2(R);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(R - 1);

    if (N < 1 || R < 1 || TMO < 1) begin : g_bad_params
        $error("vec_pipe_ctrl: N, R and TMO must all be at least 1");
    end

    vec_state_t     state, state_nx;
    logic [LW-1:0]  lane_q, lane_nx;
    logic           err_q, err_nx;
    logic           flush_q, flush_nx;
    logic           wd_clr, wd_en, wd_term;
    logic           vstart, walking, lu_hit;

    assign vstart  = LDSFlagE & (MemtoRegE | MemWriteE);
    assign walking = (state != IDLE);

    // A vector op in EX takes priority: its writeback lands before the
    // dependent reader leaves ID, so no bubble is needed.
    assign lu_hit = (state == IDLE) && !vstart && MemtoRegE &&
                    ((WA3E == RA1D) || (WA3E == RA2D));

    vec_lane_watchdog #(
        .TMO (TMO),
        .CW  (TW)
    ) u_wd (
        .clk   (clk),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .term  (wd_term)
    );

    always_comb begin
        state_nx = state;
        lane_nx  = lane_q;
        err_nx   = err_q;
        flush_nx = 1'b0;
        wd_clr   = 1'b1;
        wd_en    = 1'b0;

        unique case (state)
            IDLE: begin
                if (vstart) begin
                    lane_nx  = '0;
                    state_nx = (R == 1) ? VLAST : VWALK;
                end
            end
            VWALK: begin
                wd_clr = mem_ack;
                wd_en  = !mem_ack;
                if (mem_ack) begin
                    lane_nx = (lane_q == LANE_LAST) ? lane_q : lane_q + LW'(1);
                    if (lane_nx == LANE_LAST) begin
                        state_nx = VLAST;
                    end
                end else if (wd_term) begin
                    state_nx = IDLE;
                    lane_nx  = '0;
                    err_nx   = 1'b1;
                    flush_nx = 1'b1;
                    wd_clr   = 1'b1;
                end
            end
            VLAST: begin
                wd_clr = mem_ack;
                wd_en  = !mem_ack;
                if (mem_ack) begin
                    state_nx = IDLE;
                    lane_nx  = '0;
                end else if (wd_term) begin
                    state_nx = IDLE;
                    lane_nx  = '0;
                    err_nx   = 1'b1;
                    flush_nx = 1'b1;
                    wd_clr   = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                lane_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lane_q  <= '0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nx;
            lane_q  <= lane_nx;
            err_q   <= err_nx;
            flush_q <= flush_nx;
        end
    end

    // Outputs are forced low while reset is held, including the combinational hazard path.
    assign StallF   = ~reset & (walking | lu_hit);
    assign StallD   = ~reset & (walking | lu_hit);
    assign StallE   = ~reset & walking;
    assign FlushE   = ~reset & (lu_hit | flush_q);
    assign mem_req  = ~reset & walking;
    assign vec_busy = ~reset & walking;
    assign lane_idx = reset ? '0 : lane_q;
    assign vec_err  = ~reset & err_q;

endmodule

// File: tb/tb_vec_pipe_ctrl.sv
// Scoreboard bench for vec_pipe_ctrl: stimulus queues per-cycle expectations
// from a transaction-level model; a negedge monitor pops and compares.
module tb_vec_pipe_ctrl;

    localparam int R   = 6;
    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, WA3E;
    logic       MemtoRegE, MemWriteE, LDSFlagE, mem_ack;
    logic       StallF, StallD, StallE, FlushE, mem_req, vec_busy, vec_err;
    logic [2:0] lane_idx;

    always #5 clk = ~clk;

    vec_pipe_ctrl #(.N(8), .R(R), .TMO(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .RA1D      (RA1D),
        .RA2D      (RA2D),
        .WA3E      (WA3E),
        .MemtoRegE (MemtoRegE),
        .MemWriteE (MemWriteE),
        .LDSFlagE  (LDSFlagE),
        .mem_ack   (mem_ack),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .FlushE    (FlushE),
        .mem_req   (mem_req),
        .lane_idx  (lane_idx),
        .vec_busy  (vec_busy),
        .vec_err   (vec_err)
    );

    typedef struct packed {
        logic       stall_f;
        logic       stall_d;
        logic       stall_e;
        logic       flush_e;
        logic       req;
        logic       busy;
        logic       err;
        logic [2:0] lane;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e;
    int   errs   = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   m_err  = 1'b0;
    int   dly[R];

    function automatic obs_t sample();
        return {StallF, StallD, StallE, FlushE, mem_req, vec_busy, vec_err, lane_idx};
    endfunction

    // Expected outputs for one cycle, from the observable rules: a walk freezes
    // the whole front end and addresses one lane; a load-use hit bubbles once.
    function automatic obs_t mk(input bit walk, input bit lu, input bit fl, input int lane);
        obs_t o;
        o.stall_f = walk | lu;
        o.stall_d = walk | lu;
        o.stall_e = walk;
        o.flush_e = lu | fl;
        o.req     = walk;
        o.busy    = walk;
        o.err     = m_err;
        o.lane    = 3'(lane);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk($sformatf("cycle%0d {sf,sd,se,fe,req,busy,err,lane}", cyc), 32'(sample()), 32'(mon_e));
        end
    end

    task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                         input logic mtr, input logic mw, input logic lds, input logic ack,
                         input obs_t e);
        RA1D = ra1; RA2D = ra2; WA3E = wa;
        MemtoRegE = mtr; MemWriteE = mw; LDSFlagE = lds; mem_ack = ack;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rand();
        logic [3:0] ra1, ra2, wa;
        logic mtr, mw, lds, lu;
        ra1 = 4'($urandom_range(0, 3));
        ra2 = 4'($urandom_range(0, 3));
        wa  = 4'($urandom_range(0, 3));
        mtr = 1'($urandom_range(0, 1));
        mw  = 1'($urandom_range(0, 1));
        lds = (mtr | mw) ? 1'b0 : 1'($urandom_range(0, 1));
        lu  = mtr && (wa == ra1 || wa == ra2);
        drive(ra1, ra2, wa, mtr, mw, lds, 1'($urandom_range(0, 1)), mk(0, lu, 0, 0));
    endtask

    // One vector op: lane L waits dly[L] cycles before its ack; a lane left
    // without an ack for TMO+1 cycles is aborted.
    task automatic run_vec(input bit load, input logic [3:0] dst, input logic [3:0] src);
        bit aborted;
        aborted = 1'b0;
        drive(src, 4'($urandom), dst, load, !load, 1'b1, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0));
        for (int L = 0; L < R && !aborted; L++) begin
            for (int c = 0; ; c++) begin
                if (c > TMO) begin
                    aborted = 1'b1;
                    break;
                end
                drive(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), (c == dly[L]), mk(1, 0, 0, L));
                if (c == dly[L]) break;
            end
        end
        if (aborted) begin
            m_err = 1'b1;
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        RA1D = '0; RA2D = '0; WA3E = '0;
        MemtoRegE = 1'b0; MemWriteE = 1'b0; LDSFlagE = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(sample()), 32'(obs_t'(0)));
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset mid-walk: two lanes acked, then async reset drops everything at once.
        drive(4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0));
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0));
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1));
        mem_ack = 1'b0;
        #2;
        chk("pre_reset_lane", 32'(lane_idx), 32'd2);
        reset = 1'b1;
        #1;
        chk("midwalk_reset_outputs", 32'(sample()), 32'(obs_t'(0)));
        @(posedge clk); #1;
        reset = 1'b0;

        // Full-speed walk straight after reset: lanes 0..5 back to back.
        for (int i = 0; i < R; i++) dly[i] = 0;
        run_vec(1'b1, 4'd7, 4'd1);
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0));

        // Load-use directed cases.
        drive(4'd0, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0));
        drive(4'd4, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0));
        drive(4'd9, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, mk(0, 1, 0, 0));
        drive(4'd0, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0));
        drive(4'd6, 4'd6, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0));
        drive(4'd6, 4'd6, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0));

        // Slow memory: every lane holds three cycles.
        for (int i = 0; i < R; i++) dly[i] = 2;
        run_vec(1'b0, 4'd2, 4'd2);

        // Ack on the terminal watchdog cycle of every lane.
        for (int i = 0; i < R; i++) dly[i] = TMO;
        run_vec(1'b1, 4'd4, 4'd4);

        repeat (25) begin
            repeat ($urandom_range(0, 3)) idle_rand();
            for (int i = 0; i < R; i++)
                dly[i] = ($urandom_range(0, 3) == 0) ? TMO : $urandom_range(0, 4);
            run_vec(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end

        // Watchdog abort on lane 1; the error stays set afterwards.
        dly[0] = 0;
        for (int i = 1; i < R; i++) dly[i] = TMO + 1;
        run_vec(1'b1, 4'd1, 4'd2);
        repeat (8) idle_rand();
        for (int i = 0; i < R; i++) dly[i] = $urandom_range(0, 3);
        run_vec(1'b0, 4'd3, 4'd3);
        repeat (4) idle_rand();

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
